// File: rtl/store_trace_buffer.sv
// rtl/store_trace_buffer.sv - circular trace of processor data-memory stores, drained in order on dump
// Optional build macro STORE_TRACE_DEDUP_EN: skip stores identical (addr and data) to the last pushed entry.
module store_trace_buffer #(
  parameter int N     = 64,
  parameter int DEPTH = 16,
  parameter int CYC_W = 32
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     DM_writeEnable,
  input  logic [N-1:0]             DM_addr,
  input  logic [N-1:0]             DM_writeData,
  input  logic                     dump,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_addr,
  output logic [N-1:0]             out_data,
  output logic [CYC_W-1:0]         out_cycle,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 * N + CYC_W;

  typedef enum logic [1:0] {S_CAPTURE, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               overflow_q, overflow_d;
  logic [ENT_W-1:0]   hold_q, hold_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               store_dup;
  logic               capture_req;
  logic               full;
  logic               push;
  logic               pop;
  logic [ENT_W-1:0]   head;
  logic [ENT_W-1:0]   out_ent;

`ifdef STORE_TRACE_DEDUP_EN
  logic               ref_valid_q, ref_valid_d;
  logic [N-1:0]       ref_addr_q, ref_addr_d;
  logic [N-1:0]       ref_data_q, ref_data_d;

  // Duplicate detection against the most recently pushed store; reference moves only on a real push
  always_comb begin
    store_dup   = ref_valid_q && (DM_addr == ref_addr_q) && (DM_writeData == ref_data_q);
    ref_valid_d = ref_valid_q;
    ref_addr_d  = ref_addr_q;
    ref_data_d  = ref_data_q;
    if (push) begin
      ref_valid_d = 1'b1;
      ref_addr_d  = DM_addr;
      ref_data_d  = DM_writeData;
    end
  end

  // Dedup reference register; invalid after reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ref_valid_q <= 1'b0;
      ref_addr_q  <= '0;
      ref_data_q  <= '0;
    end else begin
      ref_valid_q <= ref_valid_d;
      ref_addr_q  <= ref_addr_d;
      ref_data_q  <= ref_data_d;
    end
  end
`else
  // Without dedup every store is a push candidate
  always_comb begin
    store_dup = 1'b0;
  end
`endif

  // Capture/drain datapath, occupancy and next-state logic
  always_comb begin
    head        = mem_q[rd_ptr_q];
    full        = (count_q == CNT_W'(DEPTH));
    capture_req = (state_q == S_CAPTURE) && DM_writeEnable && !store_dup;
    push        = capture_req && !full;
    out_valid   = (state_q == S_DRAIN) && (count_q != '0);
    pop         = out_valid && out_ready;
    done        = (state_q == S_DONE);

    out_ent     = out_valid ? head : hold_q;
    hold_d      = out_ent;

    cyc_d       = cyc_q + CYC_W'(1);
    overflow_d  = overflow_q | (capture_req && full);
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d     = count_q;
    if (push) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop) begin
      count_d = count_q - CNT_W'(1);
    end

    state_d = state_q;
    case (state_q)
      S_CAPTURE: if (dump)              state_d = S_DRAIN;
      S_DRAIN:   if (count_d == '0)     state_d = S_DONE;
      S_DONE:                           state_d = S_DONE;
      default:                          state_d = S_CAPTURE;
    endcase
  end

  assign out_addr  = out_ent[ENT_W-1 -: N];
  assign out_data  = out_ent[CYC_W +: N];
  assign out_cycle = out_ent[CYC_W-1:0];
  assign count     = count_q;
  assign overflow  = overflow_q;

  // Control and status registers
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_CAPTURE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
      hold_q     <= hold_d;
    end
  end

  // Entry storage; stale contents are unreachable once count is cleared
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {DM_addr, DM_writeData, cyc_q};
    end
  end

endmodule

// File: tb/tb_store_trace_buffer.sv
// tb/tb_store_trace_buffer.sv - scoreboard bench for store_trace_buffer
module tb_store_trace_buffer;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
    logic [31:0] c;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        dump = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [63:0] out_addr;
  logic [63:0] out_data;
  logic [31:0] out_cycle;
  logic [4:0]  count;
  logic        overflow;
  logic        done;

  int checks = 0;
  int failures = 0;

  ent_t        m_q[$];
  ent_t        exp_q[$];
  logic [31:0] m_cyc = '0;
  bit          m_ovf = 0;
  bit          m_capt = 1;
  bit          m_ref_v = 0;
  logic [63:0] m_ref_a = '0;
  logic [63:0] m_ref_d = '0;

  bit          held = 0;
  ent_t        held_v;

  store_trace_buffer #(.N(64), .DEPTH(DEPTH), .CYC_W(32)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .DM_writeEnable(we),
    .DM_addr       (addr),
    .DM_writeData  (wdata),
    .dump          (dump),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .out_cycle     (out_cycle),
    .count         (count),
    .overflow      (overflow),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus; the model decides what the buffer should hold
  task automatic step(input bit w, input logic [63:0] a, input logic [63:0] d,
                      input bit dmp, input bit rdy);
    bit dup;
    we = w; addr = a; wdata = d; dump = dmp; out_ready = rdy;
    if (m_capt) begin
      if (w) begin
        dup = 0;
`ifdef STORE_TRACE_DEDUP_EN
        dup = m_ref_v && (a == m_ref_a) && (d == m_ref_d);
`endif
        if (!dup) begin
          if (m_q.size() < DEPTH) begin
            m_q.push_back('{a: a, d: d, c: m_cyc});
            m_ref_v = 1; m_ref_a = a; m_ref_d = d;
          end else begin
            m_ovf = 1;
          end
        end
      end
      if (dmp) begin
        m_capt = 0;
        while (m_q.size() > 0) exp_q.push_back(m_q.pop_front());
      end
    end
    @(posedge clk); #1;
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic do_reset();
    reset = 1; we = 0; dump = 0; out_ready = 0; addr = '0; wdata = '0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 0;
    m_q.delete(); exp_q.delete();
    m_cyc = '0; m_ovf = 0; m_capt = 1; m_ref_v = 0;
  endtask

  task automatic check_reset_values();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_addr", out_addr, 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_cycle", 64'(out_cycle), 64'd0);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready
  task automatic drain(input int mode, input bit store_on_dump, input bit check_timing);
    int k;
    int steps;
    bit rdy;
    step(store_on_dump, 64'($urandom_range(0, 3)), 64'($urandom_range(0, 3)), 1'b1, 1'b0);
    k = exp_q.size();
    chk("drain_valid_first", 64'(out_valid), 64'(k != 0));
    steps = -1;
    for (int i = 1; i <= 300; i++) begin
      case (mode)
        0:       rdy = 1;
        1:       rdy = ((i - 1) % 4 == 0) || ((i - 1) % 4 == 3);
        default: rdy = $urandom_range(0, 1);
      endcase
      step($urandom_range(0, 1), 64'($urandom), 64'($urandom), $urandom_range(0, 1), rdy);
      if (done) begin
        steps = i;
        break;
      end
    end
    if (steps < 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=notdone required=done");
    end
    if (check_timing) chk("done_latency", 64'(steps), 64'((k > 1) ? k : 1));
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(count), 64'd0);
    chk("done_valid", 64'(out_valid), 64'd0);
    chk("done_flag", 64'(done), 64'd1);
  endtask

  // Scoreboard monitor: every accepted beat must match the next expected entry
  always @(negedge clk) begin
    if (reset) begin
      held = 0;
    end else begin
      if (held && out_valid) begin
        checks++;
        if ({out_addr, out_data, out_cycle} !== held_v) begin
          failures++;
          $display("FAIL head_stable actual=%0h required=%0h", {out_addr, out_data, out_cycle}, held_v);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", {out_addr, out_data, out_cycle});
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if ({out_addr, out_data, out_cycle} !== e) begin
            failures++;
            $display("FAIL beat actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                     out_addr, out_data, out_cycle, e.a, e.d, e.c);
          end
        end
      end
      held = out_valid && !out_ready;
      held_v = {out_addr, out_data, out_cycle};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_reset_values();

    // directed capture and drain
    repeat (3) step(0, '0, '0, 0, 0);
    step(1, 64'h10, 64'hA, 0, 0);
    step(0, '0, '0, 0, 0);
    step(1, 64'h18, 64'hB, 0, 0);
    repeat (4) step(0, '0, '0, 0, 0);
    chk("dir_count", 64'(count), 64'd2);
    step(0, '0, '0, 1, 1);
    chk("dir_first_cycle", 64'(out_cycle), 64'd3);
    chk("dir_first_addr", out_addr, 64'h10);
    step(0, '0, '0, 0, 1);
    chk("dir_done_early", 64'(done), 64'd0);
    step(0, '0, '0, 0, 1);
    chk("dir_done", 64'(done), 64'd1);
    chk("dir_left", 64'(exp_q.size()), 64'd0);
    step(0, '0, '0, 1, 1);
    chk("done_holds", 64'(done), 64'd1);

    // full buffer
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 64'($urandom), 64'($urandom), 0, 0);
    chk("full_count", 64'(count), 64'd16);
    chk("full_overflow", 64'(overflow), 64'd1);
    drain(0, 0, 1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // backpressure
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 64'($urandom), 64'($urandom), 0, 0);
    drain(1, 0, 0);

    // empty dump
    do_reset();
    drain(0, 0, 1);

    // reset mid-drain
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 64'(i + 100), 64'($urandom), 0, 0);
    step(0, '0, '0, 1, 1);
    repeat (3) step(0, '0, '0, 0, 1);
    chk("mid_left", 64'(exp_q.size()), 64'd5);
    do_reset();
    check_reset_values();
    step(1, 64'h55, 64'h66, 0, 0);
    chk("post_rst_count", 64'(count), 64'd1);
    drain(0, 0, 1);

    // dedup sequence
    do_reset();
    step(1, 64'h20, 64'd5, 0, 0);
    step(1, 64'h20, 64'd5, 0, 0);
    step(1, 64'h20, 64'd6, 0, 0);
`ifdef STORE_TRACE_DEDUP_EN
    chk("dedup_count", 64'(count), 64'd2);
`else
    chk("dedup_count", 64'(count), 64'd3);
`endif
    drain(0, 0, 1);

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      int n;
      do_reset();
      n = $urandom_range(0, 24);
      for (int i = 0; i < n; i++)
        step($urandom_range(0, 1), 64'($urandom_range(0, 3)), 64'($urandom_range(0, 3)), 0, 0);
      chk("rnd_count", 64'(count), 64'(m_q.size()));
      chk("rnd_overflow", 64'(overflow), 64'(m_ovf));
      drain(2, $urandom_range(0, 1), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
